// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, EX-stage operand
// forwarding from EX/MEM and MEM/WB, and ALU select decode.
module id_ex_stage #(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1_addr,
  input  logic [RW-1:0] id_rs2_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic [N-1:0]  id_rs1_data,
  input  logic [N-1:0]  id_rs2_data,
  input  logic [N-1:0]  id_imm,
  input  logic          id_alu_src,
  input  logic [1:0]    id_alu_op,
  input  logic [3:0]    id_funct,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_reg_write,
  input  logic [RW-1:0] mem_rd_addr,
  input  logic          mem_reg_write,
  input  logic [N-1:0]  mem_result,
  input  logic [RW-1:0] wb_rd_addr,
  input  logic          wb_reg_write,
  input  logic [N-1:0]  wb_result,
  output logic          stall,
  output logic          ex_valid,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_sel,
  output logic [N-1:0]  ex_store_data,
  output logic [RW-1:0] ex_rd_addr,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write
);

  logic          valid_q, reg_write_q, mem_read_q, mem_write_q, alu_src_q;
  logic [1:0]    alu_op_q;
  logic [3:0]    funct_q;
  logic [RW-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [N-1:0]  rs1_data_q, rs2_data_q, imm_q;
  logic [N-1:0]  fwd_rs1, fwd_rs2;

  assign ex_valid      = valid_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;

  // rs2 is compared even for immediate forms; a rare false stall is harmless.
  assign stall = ex_mem_read && (rd_addr_q != '0) && id_valid &&
                 ((id_rs1_addr == rd_addr_q) || (id_rs2_addr == rd_addr_q));

  // Bubbles only clear valid and controls; data fields keep stale values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= 2'b00;
      funct_q     <= 4'b0000;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
    end else if (flush || stall) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= id_valid;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      mem_write_q <= id_mem_write;
      alu_src_q   <= id_alu_src;
      alu_op_q    <= id_alu_op;
      funct_q     <= id_funct;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      rd_addr_q   <= id_rd_addr;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
    end
  end

  // The younger EX/MEM result takes precedence over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs1_addr_q))
      fwd_rs1 = mem_result;
    else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs1_addr_q))
      fwd_rs1 = wb_result;

    fwd_rs2 = rs2_data_q;
    if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs2_addr_q))
      fwd_rs2 = mem_result;
    else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs2_addr_q))
      fwd_rs2 = wb_result;
  end

  assign alu_a         = fwd_rs1;
  assign alu_b         = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  // funct[3] selects subtract only for register-register forms.
  always_comb begin
    alu_sel = 4'b0010;
    case (alu_op_q)
      2'b00: alu_sel = 4'b0010;
      2'b01: alu_sel = 4'b0110;
      2'b10: begin
        case (funct_q[2:0])
          3'b000:  alu_sel = (funct_q[3] && !alu_src_q) ? 4'b0110 : 4'b0010;
          3'b111:  alu_sel = 4'b0000;
          3'b110:  alu_sel = 4'b0001;
          default: alu_sel = 4'b1111;
        endcase
      end
      default: alu_sel = 4'b0010;
    endcase
  end

endmodule
